// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings and helpers for the DLX pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned FWD_W  = 2;
    localparam int unsigned PERF_W = 32;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } hazState_t;

    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    // Saturating increment for the performance counters.
    function automatic logic [PERF_W-1:0] satInc(input logic [PERF_W-1:0] v);
        return (v == {PERF_W{1'b1}}) ? v : v + PERF_W'(1);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// Operand forwarding select for one EX source register; MEM result beats WB.
module forward_unit
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] exRs,
    input  logic             memRegWrite,
    input  logic [REG_W-1:0] memRd,
    input  logic             wbRegWrite,
    input  logic [REG_W-1:0] wbRd,
    output logic [FWD_W-1:0] fwdSel
);

    // r0 is hardwired zero, so it never forwards.
    always_comb begin
        fwdSel = FWD_RF;
        if (memRegWrite && (memRd != REG_ZERO) && (memRd == exRs)) begin
            fwdSel = FWD_MEM;
        end else if (wbRegWrite && (wbRd != REG_ZERO) && (wbRd == exRs)) begin
            fwdSel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage DLX pipe: load-use stall, EX redirect
// flush, data-memory freeze with timeout, and EX operand forwarding.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CW          = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_redirect,
    input  logic              mem_reg_write,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic              mem_access,
    input  logic              mem_ready,
    input  logic              wb_reg_write,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [REG_W-1:0]  ex_rs1,
    input  logic [REG_W-1:0]  ex_rs2,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic [FWD_W-1:0]  fwd_a,
    output logic [FWD_W-1:0]  fwd_b,
    output logic              mem_err,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt,
    output logic [PERF_W-1:0] freeze_cnt
);

    hazState_t       state, nextState;
    logic [CW-1:0]   waitCnt, nextWaitCnt;
    logic            freeze, loadUse, runEval, frozen, stallEv, flushEv;

    assign freeze  = mem_access & ~mem_ready;
    assign loadUse = ex_mem_read & ex_reg_write & (ex_rd != REG_ZERO) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    // State and memory-wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            waitCnt <= '0;
        end else begin
            state   <= nextState;
            waitCnt <= nextWaitCnt;
        end
    end

    // Next state and pipeline controls; release cycle re-runs the RUN priority.
    always_comb begin
        nextState   = state;
        nextWaitCnt = waitCnt;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        runEval     = 1'b0;
        frozen      = 1'b0;
        stallEv     = 1'b0;
        flushEv     = 1'b0;

        case (state)
            RUN: begin
                runEval = 1'b1;
                if (freeze) begin
                    nextState   = MEM_WAIT;
                    nextWaitCnt = CW'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    runEval     = 1'b1;
                    nextState   = RUN;
                    nextWaitCnt = '0;
                end else if (waitCnt >= CW'(MEM_TIMEOUT)) begin
                    frozen    = 1'b1;
                    nextState = ERROR;
                end else begin
                    frozen      = 1'b1;
                    nextWaitCnt = waitCnt + CW'(1);
                end
            end
            ERROR: begin
                frozen = 1'b1;
            end
            default: begin
                nextState   = RUN;
                nextWaitCnt = '0;
            end
        endcase

        if (runEval) begin
            if (freeze) begin
                frozen = 1'b1;
            end else if (ex_redirect) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                flushEv     = 1'b1;
            end else if (loadUse) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
                stallEv     = 1'b1;
            end
        end

        if (frozen) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end

        if (reset) begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            frozen      = 1'b0;
            stallEv     = 1'b0;
            flushEv     = 1'b0;
        end
    end

    assign mem_err = (state == ERROR) & ~reset;

    forward_unit fwdUnitA (
        .exRs        (ex_rs1),
        .memRegWrite (mem_reg_write),
        .memRd       (mem_rd),
        .wbRegWrite  (wb_reg_write),
        .wbRd        (wb_rd),
        .fwdSel      (fwd_a)
    );

    forward_unit fwdUnitB (
        .exRs        (ex_rs2),
        .memRegWrite (mem_reg_write),
        .memRd       (mem_rd),
        .wbRegWrite  (wb_reg_write),
        .wbRd        (wb_rd),
        .fwdSel      (fwd_b)
    );

`ifdef HAZ_PERF_CNT_EN
    logic [PERF_W-1:0] stallCntQ, flushCntQ, freezeCntQ;

    // Saturating event counters, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCntQ  <= '0;
            flushCntQ  <= '0;
            freezeCntQ <= '0;
        end else begin
            if (stallEv) stallCntQ  <= satInc(stallCntQ);
            if (flushEv) flushCntQ  <= satInc(flushCntQ);
            if (frozen)  freezeCntQ <= satInc(freezeCntQ);
        end
    end

    assign stall_cnt  = stallCntQ;
    assign flush_cnt  = flushCntQ;
    assign freeze_cnt = freezeCntQ;
`else
    logic unusedEvents;
    assign unusedEvents = stallEv ^ flushEv ^ frozen;
    assign stall_cnt    = '0;
    assign flush_cnt    = '0;
    assign freeze_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed check of pipeline_hazard_ctrl against a
// behavioural model built from the hazard rules.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned TO = 4;
`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd, wb_rd, ex_rs1, ex_rs2;
    logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_reg_write, ex_redirect;
    logic        mem_reg_write, mem_access, mem_ready, wb_reg_write;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble, mem_err;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cnt, flush_cnt, freeze_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Model state: consecutive frozen-memory cycles, error latch, event tallies.
    int unsigned streak = 0;
    bit          mErr = 1'b0;
    int unsigned mStall = 0, mFlush = 0, mFreeze = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CW(16)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
        .ex_redirect(ex_redirect), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .mem_access(mem_access), .mem_ready(mem_ready), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit idReads(input logic [4:0] r);
        return (id_use_rs1 && id_rs1 == r) || (id_use_rs2 && id_rs2 == r);
    endfunction

    function automatic bit modelLoadUse();
        return ex_mem_read && ex_reg_write && ex_rd != 5'd0 && idReads(ex_rd);
    endfunction

    function automatic logic [1:0] modelFwd(input logic [4:0] src);
        if (src == 5'd0) return 2'b00;
        if (mem_reg_write && mem_rd == src) return 2'b10;
        if (wb_reg_write && wb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic setIdle();
        {id_rs1, id_rs2, ex_rd, mem_rd, wb_rd, ex_rs1, ex_rs2} = '0;
        {id_use_rs1, id_use_rs2, ex_mem_read, ex_reg_write, ex_redirect} = '0;
        {mem_reg_write, mem_access, wb_reg_write} = '0;
        mem_ready = 1'b1;
    endtask

    // Compare every output against what the hazard rules predict for this cycle.
    task automatic checkOutputs();
        bit frozen, lu;
        bit ePc, eIfid, eRest, eFlush, eBub, eErr;
        frozen = mem_access && !mem_ready;
        lu     = modelLoadUse();
        ePc = 1; eIfid = 1; eRest = 1; eFlush = 0; eBub = 0; eErr = 0;
        if (reset) begin
            eFlush = 1; eBub = 1;
        end else if (mErr) begin
            ePc = 0; eIfid = 0; eRest = 0; eErr = 1;
        end else if (frozen) begin
            ePc = 0; eIfid = 0; eRest = 0;
        end else if (ex_redirect) begin
            eFlush = 1; eBub = 1;
        end else if (lu) begin
            ePc = 0; eIfid = 0; eBub = 1;
        end
        checkVal("pc_en", 32'(pc_en), 32'(ePc));
        checkVal("ifid_en", 32'(ifid_en), 32'(eIfid));
        checkVal("idex_en", 32'(idex_en), 32'(eRest));
        checkVal("exmem_en", 32'(exmem_en), 32'(eRest));
        checkVal("memwb_en", 32'(memwb_en), 32'(eRest));
        checkVal("ifid_flush", 32'(ifid_flush), 32'(eFlush));
        checkVal("idex_bubble", 32'(idex_bubble), 32'(eBub));
        checkVal("mem_err", 32'(mem_err), 32'(eErr));
        checkVal("fwd_a", 32'(fwd_a), 32'(modelFwd(ex_rs1)));
        checkVal("fwd_b", 32'(fwd_b), 32'(modelFwd(ex_rs2)));
        checkVal("stall_cnt", stall_cnt, 32'(mStall));
        checkVal("flush_cnt", flush_cnt, 32'(mFlush));
        checkVal("freeze_cnt", freeze_cnt, 32'(mFreeze));
    endtask

    // Advance the model across the coming clock edge.
    task automatic updateModel();
        if (reset) begin
            mErr = 0; streak = 0; mStall = 0; mFlush = 0; mFreeze = 0;
        end else if (mErr) begin
            if (PERF) mFreeze++;
        end else if (mem_access && !mem_ready) begin
            streak++;
            if (PERF) mFreeze++;
            if (streak > TO) mErr = 1;
        end else begin
            streak = 0;
            if (ex_redirect) begin
                if (PERF) mFlush++;
            end else if (modelLoadUse()) begin
                if (PERF) mStall++;
            end
        end
    endtask

    // Inputs are already driven; check mid-cycle, then step to just past the next edge.
    task automatic cycle();
        @(negedge clk);
        checkOutputs();
        updateModel();
        @(posedge clk);
        #1;
    endtask

    initial begin
        setIdle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();

        // Load-use: one stall cycle, then MEM forwarding for the dependent op.
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1;
        #1;
        checkVal("lu_pc_en", 32'(pc_en), 32'd0);
        checkVal("lu_bubble", 32'(idex_bubble), 32'd1);
        cycle();
        setIdle();
        mem_reg_write = 1; mem_rd = 5'd5; ex_rs1 = 5'd5;
        #1;
        checkVal("lu_fwd_a", 32'(fwd_a), 32'd2);
        checkVal("lu_no_restall", 32'(pc_en), 32'd1);
        cycle();

        // Redirect overrides a simultaneous load-use.
        setIdle();
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd3; id_rs2 = 5'd3; id_use_rs2 = 1; ex_redirect = 1;
        #1;
        checkVal("rd_flush", 32'(ifid_flush), 32'd1);
        checkVal("rd_pc_en", 32'(pc_en), 32'd1);
        cycle();
        setIdle();
        cycle();

        // Freeze for three cycles then release.
        reset = 1; cycle(); reset = 0;
        mem_access = 1; mem_ready = 0;
        repeat (3) cycle();
        mem_ready = 1;
        #1;
        checkVal("frz_release", 32'(pc_en), 32'd1);
        cycle();
        setIdle();
        #1;
        checkVal("frz_cnt", freeze_cnt, PERF ? 32'd3 : 32'd0);
        cycle();

        // Timeout into ERROR, sticky until reset.
        mem_access = 1; mem_ready = 0;
        repeat (TO + 1) cycle();
        mem_ready = 1;
        #1;
        checkVal("to_err", 32'(mem_err), 32'd1);
        checkVal("to_frozen", 32'(exmem_en), 32'd0);
        cycle();
        cycle();
        reset = 1; cycle(); reset = 0; setIdle();
        #1;
        checkVal("to_cleared", 32'(mem_err), 32'd0);
        cycle();

        // Forwarding priority and r0.
        mem_reg_write = 1; wb_reg_write = 1; mem_rd = 5'd7; wb_rd = 5'd7; ex_rs1 = 5'd7;
        #1;
        checkVal("fw_mem_wins", 32'(fwd_a), 32'd2);
        cycle();
        mem_rd = 5'd0; wb_rd = 5'd0; ex_rs2 = 5'd0;
        #1;
        checkVal("fw_r0", 32'(fwd_b), 32'd0);
        cycle();

        // Reset in the middle of a memory wait restarts the timeout window.
        setIdle();
        mem_access = 1; mem_ready = 0;
        repeat (2) cycle();
        reset = 1; cycle(); reset = 0;
        setIdle();
        #1;
        checkVal("rmw_run", 32'(pc_en), 32'd1);
        checkVal("rmw_cnt", freeze_cnt, 32'd0);
        cycle();
        mem_access = 1; mem_ready = 0;
        repeat (TO) cycle();
        #1;
        checkVal("rmw_not_err", 32'(mem_err), 32'd0);
        cycle();
        #1;
        checkVal("rmw_err", 32'(mem_err), 32'd1);
        reset = 1; cycle(); reset = 0; setIdle(); cycle();

        // Random traffic with small register indices to provoke collisions.
        for (int n = 0; n < 800; n++) begin
            reset         = ($urandom_range(0, 49) == 0);
            id_rs1        = 5'($urandom_range(0, 3));
            id_rs2        = 5'($urandom_range(0, 3));
            ex_rd         = 5'($urandom_range(0, 3));
            mem_rd        = 5'($urandom_range(0, 3));
            wb_rd         = 5'($urandom_range(0, 3));
            ex_rs1        = 5'($urandom_range(0, 3));
            ex_rs2        = 5'($urandom_range(0, 3));
            id_use_rs1    = 1'($urandom_range(0, 1));
            id_use_rs2    = 1'($urandom_range(0, 1));
            ex_mem_read   = 1'($urandom_range(0, 1));
            ex_reg_write  = 1'($urandom_range(0, 1));
            mem_reg_write = 1'($urandom_range(0, 1));
            wb_reg_write  = 1'($urandom_range(0, 1));
            ex_redirect   = ($urandom_range(0, 4) == 0);
            mem_access    = ($urandom_range(0, 2) == 0);
            mem_ready     = ($urandom_range(0, 3) != 0);
            if (streak > 0 && !mErr) mem_access = 1'b1;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
